uart_receiver: RTL and testbench

Oversampling UART receive block. It converts a serial stream into parallel bytes: start bit (0), DATA_WIDTH data bits LSB first, optional parity bit, one stop bit (1). Each bit is oversampled by a runtime-programmable prescale factor. The block sits behind the system's serial RX pin on the receiver clock domain and reports a received byte, a parity error or a framing error, each as a single-cycle pulse.

---
 rtl/uart_rx_if.sv | 21 ++
 rtl/uart_receiver.sv | 114 +++++++++++
 tb/tb_uart_receiver.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: configuration, serial line and result pulses of the UART receiver
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
) ();
  logic                  parity_type;
  logic                  parity_enable;
  logic [5:0]            prescale;
  logic                  serial_data_in;
  logic                  data_valid;
  logic [DATA_WIDTH-1:0] parallel_data;
  logic                  parity_error;
  logic                  frame_error;
  modport master (
    output parity_type, parity_enable, prescale, serial_data_in,
    input  data_valid, parallel_data, parity_error, frame_error
  );
  modport slave (
    input  parity_type, parity_enable, prescale, serial_data_in,
    output data_valid, parallel_data, parity_error, frame_error
  );
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: oversampling UART receiver with 3-sample majority vote per bit
module uart_receiver #(
  parameter int DATA_WIDTH = 8
) (
  input logic      clk,
  input logic      reset,
  uart_rx_if.slave rx
);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DATA_VALID, WAIT_HIGH} state_t;
  state_t                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d, presc_q, presc_d, half;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d, pd_q, pd_d;
  logic [2:0]            smp_q, smp_d;
  logic                  pen_q, pen_d, ptype_q, ptype_d;
  logic                  pe_pend_q, pe_pend_d, fe_pend_q, fe_pend_d;
  logic                  dv_q, dv_d, perr_q, perr_d, ferr_q, ferr_d;
  logic                  din, last, s2, bit_v, rcv;
  assign din  = rx.serial_data_in;
  assign half = presc_q >> 1;
  assign last = cnt_q == presc_q - 6'd1;
  // the third sample may coincide with the decision edge when prescale is 4
  assign s2    = (cnt_q == half + 6'd1) ? din : smp_q[2];
  assign bit_v = (smp_q[0] & smp_q[1]) | (smp_q[0] & s2) | (smp_q[1] & s2);
  assign rcv   = state_q inside {START, DATA, PARITY, STOP};
  assign rx.data_valid    = dv_q;
  assign rx.parallel_data = pd_q;
  assign rx.parity_error  = perr_q;
  assign rx.frame_error   = ferr_q;
  // next-state, counters, sampling and result pulses; pulses leave one cycle after the decision edge
  always_comb begin
    state_d   = state_q;
    cnt_d     = rcv ? (last ? 6'd0 : cnt_q + 6'd1) : 6'd0;
    bit_d     = bit_q;
    sh_d      = sh_q;
    presc_d   = presc_q;
    pen_d     = pen_q;
    ptype_d   = ptype_q;
    pe_pend_d = 1'b0;
    fe_pend_d = 1'b0;
    smp_d[0]  = (cnt_q == half - 6'd1) ? din : smp_q[0];
    smp_d[1]  = (cnt_q == half) ? din : smp_q[1];
    smp_d[2]  = (cnt_q == half + 6'd1) ? din : smp_q[2];
    dv_d      = state_q == DATA_VALID;
    pd_d      = (state_q == DATA_VALID) ? sh_q : pd_q;
    perr_d    = pe_pend_q;
    ferr_d    = fe_pend_q;
    case (state_q)
      IDLE: if (!din) begin
        state_d = START;
        cnt_d   = 6'd1;
        presc_d = rx.prescale;
        pen_d   = rx.parity_enable;
        ptype_d = rx.parity_type;
      end
      START: if (last) begin
        state_d   = bit_v ? IDLE : DATA;
        fe_pend_d = bit_v;
        bit_d     = '0;
      end
      DATA: if (last) begin
        sh_d  = {bit_v, sh_q[DATA_WIDTH-1:1]};
        bit_d = bit_q + BW'(1);
        if (bit_q == BW'(DATA_WIDTH - 1)) state_d = pen_q ? PARITY : STOP;
      end
      PARITY: if (last) begin
        pe_pend_d = bit_v != (^sh_q ^ ptype_q);
        state_d   = pe_pend_d ? IDLE : STOP;
      end
      STOP: if (last) begin
        state_d   = bit_v ? DATA_VALID : WAIT_HIGH;
        fe_pend_d = !bit_v;
      end
      DATA_VALID: state_d = IDLE;
      WAIT_HIGH:  state_d = din ? IDLE : WAIT_HIGH;
      default:    state_d = IDLE;
    endcase
  end
  // state and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      pd_q      <= '0;
      smp_q     <= '0;
      presc_q   <= '0;
      pen_q     <= 1'b0;
      ptype_q   <= 1'b0;
      pe_pend_q <= 1'b0;
      fe_pend_q <= 1'b0;
      dv_q      <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      pd_q      <= pd_d;
      smp_q     <= smp_d;
      presc_q   <= presc_d;
      pen_q     <= pen_d;
      ptype_q   <= ptype_d;
      pe_pend_q <= pe_pend_d;
      fe_pend_q <= fe_pend_d;
      dv_q      <= dv_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: randomized frames against a frame-level model with a pulse scoreboard
module tb_uart_receiver;
  localparam int W = 8;
  localparam logic [2:0] K_DV = 3'b100, K_PE = 3'b010, K_FE = 3'b001;
  typedef struct {logic [2:0] kind; int cyc; logic [W-1:0] pd;} exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  exp_t sb[$];
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] last_pd = '0;
  uart_rx_if #(.DATA_WIDTH(W)) u ();
  uart_receiver #(.DATA_WIDTH(W)) dut (.clk(clk), .reset(reset), .rx(u));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // monitor: every pulse must match the oldest expected event in kind, cycle and parallel_data
  always @(negedge clk) begin
    logic [2:0] kind;
    exp_t e;
    kind = {u.data_valid, u.parity_error, u.frame_error};
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL missing_pulse: kind %b due at cycle %0d, nothing seen by cycle %0d", e.kind, e.cyc, cyc);
    end
    if (kind != 3'b000) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_pulse: kind %b at cycle %0d, data %h, none expected", kind, cyc, u.parallel_data);
      end else begin
        e = sb.pop_front();
        if (kind != e.kind || cyc != e.cyc || u.parallel_data !== e.pd) begin
          n_bad++;
          $display("FAIL pulse: got kind %b cycle %0d data %h, expected kind %b cycle %0d data %h",
                   kind, cyc, u.parallel_data, e.kind, e.cyc, e.pd);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // fault: 0 good, 1 wrong parity bit, 2 stop bit low, 3 one-cycle start glitch
  task automatic send_frame(input logic [W-1:0] b, input int p, input bit pen, input bit pt,
                            input int fault, input bit noisy);
    logic bits[$];
    int d;
    int f;
    f = (fault == 1 && !pen) ? 0 : fault;
    @(negedge clk);
    u.prescale       = 6'(p);
    u.parity_enable  = pen;
    u.parity_type    = pt;
    u.serial_data_in = 1'b0;
    d = cyc + 1;
    if (f == 3) begin
      sb.push_back('{K_FE, d + p, last_pd});
      @(negedge clk);
      u.serial_data_in = 1'b1;
      repeat (p) @(negedge clk);
      return;
    end
    bits.push_back(1'b0);
    for (int i = 0; i < W; i++) bits.push_back(b[i]);
    if (pen) bits.push_back((^b) ^ pt ^ (f == 1));
    bits.push_back(f != 2);
    if (f == 1) sb.push_back('{K_PE, d + (W + 2) * p, last_pd});
    else if (f == 2) sb.push_back('{K_FE, d + bits.size() * p, last_pd});
    else begin
      sb.push_back('{K_DV, d + bits.size() * p, b});
      last_pd = b;
    end
    for (int i = 0; i < bits.size(); i++) begin
      int flip;
      flip = (noisy && i > 0 && i <= W) ? int'($urandom_range(p - 1)) : -1;
      for (int c = 0; c < p; c++) begin
        if (i != 0 || c != 0) @(negedge clk);
        u.serial_data_in = bits[i] ^ (c == flip);
        if (i == 1 && c == 0) begin
          u.prescale      = 6'($urandom_range(2, 31));
          u.parity_enable = 1'($urandom_range(0, 1));
          u.parity_type   = 1'($urandom_range(0, 1));
        end
      end
    end
    @(negedge clk);
    u.serial_data_in = 1'b1;
  endtask
  initial begin
    u.serial_data_in = 1'b1;
    u.prescale       = 6'd8;
    u.parity_enable  = 1'b0;
    u.parity_type    = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_data_valid", 32'(u.data_valid), 0);
    chk("reset_parallel_data", 32'(u.parallel_data), 0);
    chk("reset_parity_error", 32'(u.parity_error), 0);
    chk("reset_frame_error", 32'(u.frame_error), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    send_frame(8'h6A, 8, 1, 0, 0, 0);
    send_frame(8'hA5, 8, 0, 0, 0, 0);
    send_frame(8'h5A, 8, 0, 0, 0, 0);
    send_frame(8'hF7, 8, 1, 1, 0, 0);
    send_frame(8'h00, 8, 0, 0, 3, 0);
    send_frame(8'h3C, 8, 0, 0, 0, 0);
    send_frame(8'h57, 8, 1, 1, 1, 0);
    send_frame(8'h88, 8, 0, 0, 2, 0);
    repeat (3) @(negedge clk);
    send_frame(8'hC3, 4, 1, 0, 0, 0);
    send_frame(8'h1E, 32, 1, 1, 0, 0);
    for (int n = 0; n < 40; n++) begin
      int p;
      int r;
      bit pen;
      p   = 2 * int'($urandom_range(2, 16));
      pen = 1'($urandom_range(0, 1));
      r   = int'($urandom_range(0, 9));
      send_frame(W'($urandom()), p, pen, 1'($urandom_range(0, 1)),
                 r < 6 ? 0 : r == 6 ? 1 : r == 7 ? 2 : r == 8 ? 3 : 0, 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    @(negedge clk);
    u.prescale       = 6'd8;
    u.parity_enable  = 1'b0;
    u.serial_data_in = 1'b0;
    for (int c = 0; c < 37; c++) begin
      @(negedge clk);
      u.serial_data_in = c[3];
    end
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_data_valid", 32'(u.data_valid), 0);
    chk("midreset_parallel_data", 32'(u.parallel_data), 0);
    chk("midreset_parity_error", 32'(u.parity_error), 0);
    chk("midreset_frame_error", 32'(u.frame_error), 0);
    u.serial_data_in = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    last_pd = '0;
    repeat (2) @(negedge clk);
    send_frame(8'h88, 8, 0, 0, 2, 0);
    send_frame(8'h96, 8, 1, 0, 0, 0);
    repeat (6) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    chk("final_parallel_data", 32'(u.parallel_data), 32'h96);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
